ln_result_serializer: RTL and testbench



---
 rtl/ln_result_serializer.sv | 186 ++++++++++++++++++
 tb/tb_ln_result_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln_result_serializer.sv
// ln_result_serializer
//
// Buffers whole 64 x 16-bit LayerNorm result vectors in a small circular
// store and streams each one out as BEATS narrow beats of LANES words over a
// valid/ready interface. The LayerNorm pipeline cannot be stalled, so a
// vector arriving while the store is full is dropped and flagged through the
// sticky o_overflow output.
//
// Optional feature macro: LN_SER_DROPCNT_EN
//   defined   -> o_drop_cnt counts dropped vectors, saturating at 255
//   undefined -> o_drop_cnt is tied to zero and no counter is built
//
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
// LANES must divide 64.

module ln_result_serializer #(
    parameter int DEPTH = 4,
    parameter int LANES = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic [1023:0]                i_data_flat,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [16*LANES-1:0]          o_data,
    output logic                         o_last,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_overflow,
    output logic [7:0]                   o_drop_cnt
);

    localparam int WORDS      = 64;
    localparam int VEC_W      = 16 * WORDS;
    localparam int BEAT_W     = 16 * LANES;
    localparam int BEATS      = WORDS / LANES;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int LVL_W      = $clog2(DEPTH + 1);
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [LVL_W-1:0]      FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]      LVL_ONE    = LVL_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT  = BEAT_CNT_W'(BEATS - 1);
    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE   = BEAT_CNT_W'(1);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Vector store; deliberately not reset, its contents are only exposed
    // while at least one vector is held.
    logic [VEC_W-1:0]      mem [DEPTH];

    state_t                state;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      count;
    logic [BEAT_CNT_W-1:0] beat;

    logic                  xfer;
    logic                  final_xfer;
    logic                  accept;
    logic                  drop;
    logic                  wr_en;
    logic [LVL_W-1:0]      count_next;
    logic [BEAT_CNT_W-1:0] beat_next;
    logic [VEC_W-1:0]      rd_vec;

    // Handshake decode and next occupancy / beat position. A full store can
    // still take a vector when the head vector finishes in the same cycle.
    always_comb begin
        xfer       = o_valid & i_ready;
        final_xfer = xfer & (beat == LAST_BEAT);
        accept     = i_valid & ((count != FULL_LEVEL) | final_xfer);
        drop       = i_valid & ~accept;
        wr_en      = accept & ~i_rst;

        count_next = count;
        if (accept && !final_xfer) begin
            count_next = count + LVL_ONE;
        end else if (final_xfer && !accept) begin
            count_next = count - LVL_ONE;
        end

        beat_next = beat;
        if (final_xfer) begin
            beat_next = '0;
        end else if (xfer) begin
            beat_next = beat + BEAT_ONE;
        end
    end

    // Control FSM: pointers, occupancy, beat position and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat       <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            count <= count_next;
            beat  <= beat_next;

            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (final_xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end

            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state   <= S_STREAM;
                        o_valid <= 1'b1;
                        o_last  <= (beat_next == LAST_BEAT);
                    end
                end
                S_STREAM: begin
                    if (count_next == '0) begin
                        state   <= S_EMPTY;
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                    end else begin
                        o_valid <= 1'b1;
                        o_last  <= (beat_next == LAST_BEAT);
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end
            endcase
        end
    end

    // Store an accepted vector at the write pointer; input is ignored in reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_data_flat;
        end
    end

    // Select the current beat of the head vector; zero while nothing is held.
    always_comb begin
        rd_vec = mem[rd_ptr];
        o_data = '0;
        if (o_valid) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat == BEAT_CNT_W'(b)) begin
                    o_data = rd_vec[b*BEAT_W +: BEAT_W];
                end
            end
        end
    end

    assign o_level = count;

`ifdef LN_SER_DROPCNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of dropped vectors, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ln_result_serializer.sv
// tb_ln_result_serializer
//
// Directed bench for ln_result_serializer (DEPTH=4, LANES=4). A queue-based
// model of the vector store runs alongside the design and is compared with
// every output on each falling clock edge; directed scenarios add literal
// expectations for beat contents, drain timing, overflow and reset.

module tb_ln_result_serializer;

    localparam int DEPTH = 4;
    localparam int LANES = 4;
    localparam int BEATS = 64 / LANES;
    localparam int BW    = 16 * LANES;

    logic            clk;
    logic            i_rst;
    logic            i_valid;
    logic [1023:0]   i_data_flat;
    logic            i_ready;
    logic            o_valid;
    logic [BW-1:0]   o_data;
    logic            o_last;
    logic [2:0]      o_level;
    logic            o_overflow;
    logic [7:0]      o_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Reference model state
    logic [1023:0] mq [$];
    int            m_beat;
    bit            m_ov;
    int            m_drop;
    int            m_sz;
    bit            m_done;
    logic [1023:0] m_head;

    ln_result_serializer #(
        .DEPTH(DEPTH),
        .LANES(LANES)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data_flat(i_data_flat),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_level    (o_level),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1023:0] d, input logic r);
        i_valid     = v;
        i_data_flat = d;
        i_ready     = r;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic applyReset();
        i_rst       = 1'b1;
        i_valid     = 1'b1;
        i_data_flat = {64{16'h7777}};
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
    endtask

    function automatic logic [1023:0] makeVec(input logic [15:0] w0, input logic [15:0] step);
        logic [1023:0] v;
        for (int k = 0; k < 64; k++) begin
            v[16*k +: 16] = w0 + step * 16'(k);
        end
        return v;
    endfunction

    // Model update: a queue of held vectors plus the beat position of the head.
    always @(posedge clk) begin
        if (i_rst) begin
            mq.delete();
            m_beat = 0;
            m_ov   = 0;
            m_drop = 0;
        end else begin
            m_sz   = mq.size();
            m_done = 0;
            if (m_sz > 0 && i_ready) begin
                if (m_beat == BEATS - 1) begin
                    mq.delete(0);
                    m_beat = 0;
                    m_done = 1;
                end else begin
                    m_beat++;
                end
            end
            if (i_valid) begin
                if (m_sz < DEPTH || m_done) begin
                    mq.push_back(i_data_flat);
                end else begin
                    m_ov = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    // Compare every output with the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("m_valid", 64'(o_valid), 64'(mq.size() > 0));
            checkOutput("m_level", 64'(o_level), 64'(mq.size()));
            checkOutput("m_last", 64'(o_last), 64'(mq.size() > 0 && m_beat == BEATS - 1));
            checkOutput("m_overflow", 64'(o_overflow), 64'(m_ov));
`ifdef LN_SER_DROPCNT_EN
            checkOutput("m_drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
`else
            checkOutput("m_drop_cnt", 64'(o_drop_cnt), 64'd0);
`endif
            if (mq.size() > 0) begin
                m_head = mq[0];
                checkOutput("m_data", 64'(o_data), 64'(m_head[m_beat*BW +: BW]));
            end
        end
    end

    initial begin
        logic [1023:0] vec_a;
        logic [1023:0] vec_t;
        logic [63:0]   last_data;
        logic [63:0]   exp_beat;
        logic [15:0]   exp4 [4];
        logic          r;
        int            n;
        int            nv;
        int            tr;
        int            l1;
        int            l2;
        int            nl;

        clk         = 1'b0;
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_data_flat = '0;
        i_ready     = 1'b0;
        vec_a       = makeVec(16'h0100, 16'h0001);

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_rst  = 1'b0;
        chk_en = 1;

        $display("[TB] reset state");
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_last", 64'(o_last), 64'd0);
        checkOutput("rst_level", 64'(o_level), 64'd0);
        checkOutput("rst_overflow", 64'(o_overflow), 64'd0);
        checkOutput("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);

        $display("[TB] single vector, ready held high");
        applyStimulus(1'b1, vec_a, 1'b1);
        checkOutput("t1_beat0", o_data, 64'h0103_0102_0101_0100);
        n = 0;
        last_data = '0;
        for (int c = 0; c < 40 && o_valid; c++) begin
            if (o_last) last_data = o_data;
            n++;
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t1_valid_cycles", 64'(n), 64'd16);
        checkOutput("t1_beat15", last_data, 64'h013F_013E_013D_013C);
        checkOutput("t1_valid_after", 64'(o_valid), 64'd0);
        checkOutput("t1_level_after", 64'(o_level), 64'd0);

        $display("[TB] single vector, ready alternating");
        applyStimulus(1'b1, vec_a, 1'b1);
        n = 0;
        tr = 0;
        r = 1'b0;
        last_data = '0;
        for (int c = 0; c < 80 && o_valid; c++) begin
            exp_beat = vec_a[tr*BW +: BW];
            checkOutput("t2_beat", o_data, exp_beat);
            if (o_last && r) last_data = o_data;
            applyStimulus(1'b0, '0, r);
            n++;
            if (r) begin
                tr++;
            end else begin
                checkOutput("t2_stall_hold", o_data, exp_beat);
            end
            r = ~r;
        end
        checkOutput("t2_drain_cycles", 64'(n), 64'd32);
        checkOutput("t2_transfers", 64'(tr), 64'd16);
        checkOutput("t2_beat15", last_data, 64'h013F_013E_013D_013C);

        $display("[TB] five vectors into a stalled four-deep store");
        applyReset();
        for (int t = 1; t <= 5; t++) begin
            applyStimulus(1'b1, makeVec(16'(t), 16'h0100), 1'b0);
        end
        checkOutput("t3_level", 64'(o_level), 64'd4);
        checkOutput("t3_overflow", 64'(o_overflow), 64'd1);
`ifdef LN_SER_DROPCNT_EN
        checkOutput("t3_drop_cnt", 64'(o_drop_cnt), 64'd1);
`else
        checkOutput("t3_drop_cnt", 64'(o_drop_cnt), 64'd0);
`endif
        checkOutput("t3_first_word", 64'(o_data[15:0]), 64'h0001);
        nv = 0;
        for (int c = 0; c < 200 && o_valid; c++) begin
            if (o_last) begin
                nv++;
                checkOutput($sformatf("t3_vec%0d_order", nv), 64'(o_data[15:0]), 64'(16'h3C00 + 16'(nv)));
            end
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t3_vec_count", 64'(nv), 64'd4);
        checkOutput("t3_drained", 64'(o_valid), 64'd0);
        checkOutput("t3_overflow_sticky", 64'(o_overflow), 64'd1);

        $display("[TB] write into full store on the final-beat handshake");
        applyReset();
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(1'b1, makeVec(16'(t), 16'h0100), 1'b0);
        end
        checkOutput("t4_level_full", 64'(o_level), 64'd4);
        for (int c = 0; c < 15; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t4_at_last_beat", 64'(o_last), 64'd1);
        applyStimulus(1'b1, makeVec(16'd6, 16'h0100), 1'b1);
        checkOutput("t4_level_kept", 64'(o_level), 64'd4);
        checkOutput("t4_no_overflow", 64'(o_overflow), 64'd0);
        exp4[0] = 16'h3C02;
        exp4[1] = 16'h3C03;
        exp4[2] = 16'h3C04;
        exp4[3] = 16'h3C06;
        nv = 0;
        for (int c = 0; c < 200 && o_valid; c++) begin
            if (o_last) begin
                if (nv < 4) checkOutput($sformatf("t4_vec%0d_order", nv), 64'(o_data[15:0]), 64'(exp4[nv]));
                nv++;
            end
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t4_vec_count", 64'(nv), 64'd4);

        $display("[TB] reset in the middle of a vector");
        applyReset();
        vec_t = makeVec(16'd1, 16'h0100);
        for (int t = 1; t <= 3; t++) begin
            applyStimulus(1'b1, makeVec(16'(t), 16'h0100), 1'b0);
        end
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t5_beat7", o_data, vec_t[7*BW +: BW]);
        applyReset();
        checkOutput("t5_valid", 64'(o_valid), 64'd0);
        checkOutput("t5_level", 64'(o_level), 64'd0);
        checkOutput("t5_overflow", 64'(o_overflow), 64'd0);
        checkOutput("t5_last", 64'(o_last), 64'd0);
        applyStimulus(1'b1, vec_a, 1'b1);
        checkOutput("t5_new_beat0", o_data, 64'h0103_0102_0101_0100);
        checkOutput("t5_new_level", 64'(o_level), 64'd1);
        n = 0;
        for (int c = 0; c < 40 && o_valid; c++) begin
            n++;
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t5_new_cycles", 64'(n), 64'd16);

        $display("[TB] two vectors on consecutive cycles");
        applyReset();
        applyStimulus(1'b1, makeVec(16'h0A00, 16'h0001), 1'b1);
        n = 0;
        nl = 0;
        l1 = 0;
        l2 = 0;
        for (int c = 0; c < 100; c++) begin
            if (!o_valid) break;
            n++;
            if (o_last) begin
                nl++;
                if (nl == 1) l1 = n;
                else l2 = n;
            end
            applyStimulus(c == 0, makeVec(16'h0B00, 16'h0001), 1'b1);
        end
        checkOutput("t6_beats", 64'(n), 64'd32);
        checkOutput("t6_last1", 64'(l1), 64'd16);
        checkOutput("t6_last2", 64'(l2), 64'd32);
        checkOutput("t6_level_after", 64'(o_level), 64'd0);

        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
